// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell, LSB first, registered carry.
// Latency WIDTH cycles from accept; the result is held in DONE until the consumer accepts it.

module full_adder_using_half_substractors (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic d1, bo1, d2, bo2;

  // Two half subtractors: the difference bits give the XOR chain, and the
  // inverted borrows recover the AND terms of the carry.
  assign d1   = a ^ b;
  assign bo1  = ~a & b;
  assign d2   = d1 ^ cin;
  assign bo2  = ~d1 & cin;
  assign sum  = d2;
  assign cout = (b & ~bo1) | (cin & ~bo2);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  full_adder_using_half_substractors u_cell (
    .a    (sha[0]),
    .b    (shb[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign res_next  = {fa_s, res[WIDTH-1:1]};
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sha      <= '0;
      shb      <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, so invert B and force the carry-in.
            sha   <= a;
            shb   <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= fa_c;
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          if (last_bit) begin
            state    <= DONE;
            sum      <= res_next;
            cout     <= fa_c;
            overflow <= (a_msb == b_msb) && (fa_s != a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16.
// Stimulus pushes expected results; per-DUT monitors pop and compare on each output handshake.

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_mode = 1;

  logic       iv8, ir8, cin8, sub8, ov8, or8, cout8, ovf8, busy8;
  logic [7:0] a8, b8, sum8;
  logic        iv16, ir16, cin16, sub16, ov16, or16, cout16, ovf16, busy16;
  logic [15:0] a16, b16, sum16;

  logic [33:0] q8[$];
  logic [33:0] q16[$];
  logic [33:0] e8, e16;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(cout8), .overflow(ovf8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(cout16), .overflow(ovf16), .busy(busy16)
  );

  function automatic logic [33:0] pack(input logic o, input logic c, input logic [31:0] s);
    return {o, c, s};
  endfunction

  // Reference: A + B + cin, or A + ~B + 1 for subtraction, truncated to w bits.
  function automatic logic [33:0] model(input int w, input logic [31:0] ta, input logic [31:0] tb_,
                                        input logic tc, input logic ts);
    logic [32:0] m, full;
    logic [31:0] beff, s;
    logic        co, ov;
    m    = (33'd1 << w) - 33'd1;
    beff = (ts ? ~tb_ : tb_) & m[31:0];
    full = {1'b0, ta & m[31:0]} + {1'b0, beff} + {32'd0, (ts | tc)};
    s    = full[31:0] & m[31:0];
    co   = full[w];
    ov   = (ta[w-1] == beff[w-1]) && (s[w-1] != ta[w-1]);
    return pack(ov, co, s);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // out_ready drivers: 0 = held low, 1 = held high, otherwise random gaps.
  initial begin
    or8 = 1'b0;
    or16 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       begin or8 = 1'b0; or16 = 1'b0; end
        1:       begin or8 = 1'b1; or16 = 1'b1; end
        default: begin
          or8  = ($urandom_range(0, 3) != 0);
          or16 = ($urandom_range(0, 2) != 0);
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ov8 && or8) begin
        if (q8.size() == 0) fail_now("unexpected_result8");
        else begin
          e8 = q8.pop_front();
          check("result8", {ovf8, cout8, 24'd0, sum8}, e8);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ov16 && or16) begin
        if (q16.size() == 0) fail_now("unexpected_result16");
        else begin
          e16 = q16.pop_front();
          check("result16", {ovf16, cout16, 16'd0, sum16}, e16);
        end
      end
    end
  end

  // Returns on the falling edge just after the accept edge.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
    int g;
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts; iv8 = 1'b1;
    g = 0;
    while (!ir8 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ir8) fail_now("accept8_timeout");
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
    int g;
    @(negedge clk);
    a16 = ta; b16 = tb_; cin16 = tc; sub16 = ts; iv16 = 1'b1;
    g = 0;
    while (!ir16 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ir16) fail_now("accept16_timeout");
    @(negedge clk);
    iv16 = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((q8.size() != 0 || q16.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (q8.size() != 0 || q16.size() != 0) fail_now(name);
  endtask

  logic [7:0] va[4]  = '{8'hFF, 8'h7F, 8'h05, 8'h80};
  logic [7:0] vb[4]  = '{8'h01, 8'h01, 8'h07, 8'h01};
  logic       vc[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       vs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [33:0] vx[4] = '{34'h1_0000_0001, 34'h2_0000_0080, 34'h0_0000_00FE, 34'h3_0000_007F};

  initial begin
    int k, nb;
    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    #12;
    check("reset_in_ready", ir8, 1);
    check("reset_out_valid", ov8, 0);
    check("reset_busy", busy8, 0);
    check("reset_outputs", {ovf8, cout8, sum8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add with latency and busy-width measurement.
    q8.push_back(pack(1'b0, 1'b0, 32'h4B));
    issue8(8'h3C, 8'h0F, 1'b0, 1'b0);
    k = 0; nb = 0;
    while (!ov8 && k < 100) begin
      if (busy8) nb++;
      @(negedge clk);
      k++;
    end
    check("latency", k, 8);
    check("busy_cycles", nb, 8);
    check("busy_in_done", busy8, 0);

    for (int i = 0; i < 4; i++) begin
      q8.push_back(vx[i]);
      issue8(va[i], vb[i], vc[i], vs[i]);
    end
    drain("drain_directed");

    // Backpressure: outputs and in_ready frozen while inputs wiggle.
    rdy_mode = 0;
    q8.push_back(pack(1'b0, 1'b0, 32'h46));
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    k = 0;
    while (!ov8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ov8) fail_now("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      iv8 = ~iv8;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(negedge clk);
      check("bp_hold", {ov8, ir8, ovf8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h46});
    end
    iv8 = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after_accept", {ir8, ov8}, 2'b10);

    // Asynchronous reset in the middle of RUN.
    issue8(8'h55, 8'h22, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("busy_before_reset", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {ov8, ir8, busy8, sum8}, {1'b0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    q8.push_back(pack(1'b0, 1'b0, 32'h02));
    issue8(8'h01, 8'h01, 1'b0, 1'b0);
    drain("drain_after_reset");

    rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] ra, rb;
          logic rc, rs;
          ra = 8'($urandom); rb = 8'($urandom);
          rc = 1'($urandom); rs = 1'($urandom);
          q8.push_back(model(8, {24'd0, ra}, {24'd0, rb}, rc, rs));
          issue8(ra, rb, rc, rs);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [15:0] ra, rb;
          logic rc, rs;
          ra = 16'($urandom); rb = 16'($urandom);
          rc = 1'($urandom); rs = 1'($urandom);
          q16.push_back(model(16, {16'd0, ra}, {16'd0, rb}, rc, rs));
          issue16(ra, rb, rc, rs);
        end
      end
    join
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
